multicycle_controller: RTL and testbench

- Control FSM for the multicycle RV32I datapath.
- Sequences one shared ALU, one unified instruction/data memory port and the register file across multiple cycles per instruction.
- Decodes the opcode held in the instruction register (IR) and drives every mux select and write-enable.
- Stalls on a memory-ready handshake, so the same core works with single-cycle or wait-stated memory.

---
 rtl/multicycle_controller_if.sv | 34 +++
 rtl/multicycle_controller.sv | 159 +++++++++++++++
 tb/tb_multicycle_controller.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle RV32I datapath (master) and its controller (slave).
// The controller exposes its state on State for checkers and debug.
interface multicycle_controller_if;
  // Memory handshake: the controller holds the request (address select, MemWrite, or the
  // FETCH enables) steady each cycle. The access completes in the cycle MemReady is high.
  // MemReady may stay low for any number of cycles, and nothing advances until it is high.
  logic [6:0] Op;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [1:0] ALUOp;
  logic [3:0] State;
  logic       IllegalOp;

  modport master (
    output Op, Zero, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUOp, State, IllegalOp
  );

  modport slave (
    input  Op, Zero, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUOp, State, IllegalOp
  );
endinterface

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core. It is a Moore machine with Mealy terms for MemReady and Zero.
// Optional macro MCYC_INSTR_CNT_EN adds the InstrCount retired-fetch counter output.
module multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input logic                  clk,
  input logic                  rst_n,
  multicycle_controller_if.slave bus
`ifdef MCYC_INSTR_CNT_EN
  ,
  output logic [31:0]          InstrCount
`endif
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  state_t r_state;
  state_t w_next;
  logic   w_pcwrite;
  logic   w_irwrite;
  logic   w_regwrite;
  logic   w_memwrite;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= state_t'(RESET_STATE);
    else        r_state <= w_next;
  end

  always_comb begin
    w_next         = FETCH;
    w_pcwrite      = 1'b0;
    w_irwrite      = 1'b0;
    w_regwrite     = 1'b0;
    w_memwrite     = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.ResultSrc  = 2'b00;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.ALUOp      = 2'b00;
    bus.IllegalOp  = 1'b0;
    case (r_state)
      FETCH: begin
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        w_irwrite     = bus.MemReady;
        w_pcwrite     = bus.MemReady;
        w_next        = bus.MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        // PC-relative branch target is computed here and parked in ALUOut.
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
        case (bus.Op)
          OP_LOAD, OP_STORE: w_next = MEMADR;
          OP_RTYPE:          w_next = EXECUTER;
          OP_ITYPE:          w_next = EXECUTEI;
          OP_BEQ:            w_next = BEQ;
          OP_JAL:            w_next = JAL;
          default:           w_next = TRAP;
        endcase
      end
      MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        w_next      = (bus.Op == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        bus.AdrSrc = 1'b1;
        w_next     = bus.MemReady ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        w_regwrite    = 1'b1;
      end
      MEMWRITE: begin
        bus.AdrSrc = 1'b1;
        w_memwrite = 1'b1;
        w_next     = bus.MemReady ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUOp   = 2'b10;
        w_next      = ALUWB;
      end
      EXECUTEI: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        bus.ALUOp   = 2'b10;
        w_next      = ALUWB;
      end
      ALUWB: w_regwrite = 1'b1;
      BEQ: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUOp   = 2'b01;
        w_pcwrite   = bus.Zero;
      end
      JAL: begin
        // PC <= branch target from DECODE, while the ALU forms OldPC+4 for the rd writeback.
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        w_pcwrite   = 1'b1;
        w_next      = ALUWB;
      end
      TRAP: begin
        bus.IllegalOp = 1'b1;
        w_next        = TRAP;
      end
      default: w_next = FETCH;
    endcase
  end

  always_comb begin
    case (bus.Op)
      OP_STORE: bus.ImmSrc = 2'b01;
      OP_BEQ:   bus.ImmSrc = 2'b10;
      OP_JAL:   bus.ImmSrc = 2'b11;
      default:  bus.ImmSrc = 2'b00;
    endcase
  end

  // Reset gates the enables combinationally, so an abandoned instruction never writes.
  assign bus.PCWrite  = w_pcwrite  & rst_n;
  assign bus.IRWrite  = w_irwrite  & rst_n;
  assign bus.RegWrite = w_regwrite & rst_n;
  assign bus.MemWrite = w_memwrite & rst_n;
  assign bus.State    = r_state;

`ifdef MCYC_INSTR_CNT_EN
  logic [31:0] r_instr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              r_instr_cnt <= '0;
    else if ((r_state == FETCH) && w_irwrite) r_instr_cnt <= r_instr_cnt + 32'd1;
  end

  assign InstrCount = r_instr_cnt;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller.
// Each table row holds one cycle of inputs and the expected outputs for that cycle.
module tb_multicycle_controller;
  logic clk;
  logic rst_n;
  multicycle_controller_if bus ();

`ifdef MCYC_INSTR_CNT_EN
  logic [31:0] instr_count;
`endif

  multicycle_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MCYC_INSTR_CNT_EN
    ,
    .InstrCount (instr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] R = 7'b0110011;
  localparam logic [6:0] I = 7'b0010011;
  localparam logic [6:0] L = 7'b0000011;
  localparam logic [6:0] S = 7'b0100011;
  localparam logic [6:0] B = 7'b1100011;
  localparam logic [6:0] J = 7'b1101111;
  localparam logic [6:0] T = 7'b1111111;

  typedef struct {
    logic [6:0]  op;
    logic        zero;
    logic        mr;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Expected layout: {State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp, IllegalOp}
  function automatic logic [19:0] ev(logic [3:0] st, logic pcw, logic adr, logic mw, logic irw,
                                     logic rw, logic [1:0] res, logic [1:0] a, logic [1:0] b,
                                     logic [1:0] imm, logic [1:0] aop, logic ill);
    return {st, pcw, adr, mw, irw, rw, res, a, b, imm, aop, ill};
  endfunction

  task automatic add(logic [6:0] op, logic z, logic mr, logic [19:0] e);
    vec_t v;
    v.op = op; v.zero = z; v.mr = mr; v.exp = e;
    vecs.push_back(v);
  endtask

  function automatic logic [19:0] actual();
    return {bus.State, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
            bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUOp, bus.IllegalOp};
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic [6:0] op, logic z, logic mr);
    bus.Op = op; bus.Zero = z; bus.MemReady = mr;
  endtask

  initial begin
    // R-type, with one fetch wait first
    add(R, 0, 0, ev(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0));
    add(R, 0, 1, ev(0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0));
    add(R, 0, 1, ev(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0));
    add(R, 0, 1, ev(6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 0));
    add(R, 0, 1, ev(8, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    // I-type
    add(I, 0, 1, ev(0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0));
    add(I, 0, 1, ev(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0));
    add(I, 0, 1, ev(7, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b10, 0));
    add(I, 0, 1, ev(8, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    // lw with two memory wait cycles
    add(L, 0, 1, ev(0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0));
    add(L, 0, 1, ev(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0));
    add(L, 0, 1, ev(2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 0));
    add(L, 0, 0, ev(3, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    add(L, 0, 0, ev(3, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    add(L, 0, 1, ev(3, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    add(L, 0, 1, ev(4, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    // sw with three memory wait cycles: MemWrite high for four cycles
    add(S, 0, 1, ev(0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b01, 2'b00, 0));
    add(S, 0, 1, ev(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 0));
    add(S, 0, 1, ev(2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 2'b00, 0));
    add(S, 0, 0, ev(5, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 0));
    add(S, 0, 0, ev(5, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 0));
    add(S, 0, 0, ev(5, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 0));
    add(S, 0, 1, ev(5, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 0));
    // beq taken, then not taken
    add(B, 1, 1, ev(0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b10, 2'b00, 0));
    add(B, 1, 1, ev(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00, 0));
    add(B, 1, 1, ev(9, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b01, 0));
    add(B, 0, 1, ev(0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b10, 2'b00, 0));
    add(B, 0, 1, ev(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00, 0));
    add(B, 0, 1, ev(9, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b01, 0));
    // jal
    add(J, 0, 1, ev(0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b11, 2'b00, 0));
    add(J, 0, 1, ev(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 0));
    add(J, 0, 1, ev(10, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 0));
    add(J, 0, 1, ev(8, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 0));
    // illegal opcode -> TRAP, held for 10 cycles
    add(T, 0, 1, ev(0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0));
    add(T, 0, 1, ev(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0));
    for (int k = 0; k < 10; k++)
      add(T, 0, 1, ev(11, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1));

    // Reset state: held in reset with MemReady high, enables must stay low
    drive(R, 0, 1);
    rst_n = 1'b0;
    #1;
    check("reset_state", 32'(actual()), 32'(ev(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0)));
`ifdef MCYC_INSTR_CNT_EN
    check("cnt_reset", instr_count, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].zero, vecs[i].mr);
      #1;
      check($sformatf("vec%0d", i), 32'(actual()), 32'(vecs[i].exp));
      @(negedge clk);
    end

    // Asynchronous reset mid-cycle while sitting in TRAP
    #2;
    rst_n = 1'b0;
    #1;
    check("trap_async_reset", 32'(actual()), 32'(ev(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0)));
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a stalled store: MemWrite must drop at once
    drive(S, 0, 1);
    @(negedge clk);
    @(negedge clk);
    drive(S, 0, 0);
    @(negedge clk);
    #1;
    check("sw_in_memwrite", 32'(actual()), 32'(ev(5, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 0)));
    #2;
    rst_n = 1'b0;
    #1;
    check("sw_abandon_reset", 32'(actual()), 32'(ev(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b01, 2'b00, 0)));
    @(negedge clk);
    rst_n = 1'b1;

    // After reset release, the first edge must fetch
    drive(R, 0, 1);
    #1;
    check("post_reset_fetch", 32'(actual()), 32'(ev(0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0)));
`ifdef MCYC_INSTR_CNT_EN
    check("cnt_after_reset", instr_count, 32'd0);
`endif
    repeat (12) @(negedge clk);
    #1;
    check("r3_back_in_fetch", 32'(bus.State), 32'd0);
`ifdef MCYC_INSTR_CNT_EN
    check("cnt_three_rtype", instr_count, 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
